// File: rtl/project_types.sv
// Shared fetch-path types: instruction address/data words and the fetch-buffer entry.
package project_types;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_data_t;

  localparam inst_addr_t INST_STEP = 32'd4;

  typedef struct packed {
    inst_addr_t pc;
    inst_data_t inst;
    logic       misalign;
  } fetch_entry_t;

endpackage

// File: rtl/i_instbus.sv
// Synchronous instruction-ROM port: data returns one cycle after a cycle with en=1.
interface i_instbus;
  import project_types::*;

  logic       en;
  inst_addr_t addr;
  inst_data_t data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries, fall-through head (an arriving push is visible
// at once when empty), flush drops everything not popped this cycle.
module fetch_fifo
  import project_types::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic          head_valid,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  rd_ptr_r;
  logic [AW-1:0]  wr_ptr_r;
  logic [CW-1:0]  count_r;
  logic           empty_s;
  logic           bypass_s;
  logic           wr_en_s;
  logic           rd_en_s;

  // Head selection and write/read enables; a push popped while empty never lands.
  always_comb begin
    empty_s    = (count_r == {CW{1'b0}});
    head_valid = !empty_s || push;
    bypass_s   = empty_s && push && pop;
    wr_en_s    = push && !bypass_s && !flush;
    rd_en_s    = pop && !empty_s && !flush;
    if (!empty_s) begin
      head = mem_r[rd_ptr_r];
    end else if (push) begin
      head = push_entry;
    end else begin
      head = '0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + {{(CW-1){1'b0}}, wr_en_s} - {{(CW-1){1'b0}}, rd_en_s};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC sequencing, redirect handling, fetch buffer.
// FETCH_ALIGN_CHK_EN: misaligned redirect targets become a single fault entry.
module inst_fetch
  import project_types::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter int         DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  i_instbus.master   ibus,
  input  logic       redirect_valid,
  input  inst_addr_t redirect_pc,
  output logic       out_valid,
  input  logic       out_ready,
  output inst_addr_t out_pc,
  output inst_data_t out_inst,
  output logic       out_misalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  inst_addr_t   pc_r;
  inst_addr_t   inflight_pc_r;
  logic         inflight_r;
  logic         halt_r;
  logic         fault_pend_r;
  inst_addr_t   tgt_s;
  logic         mis_s;
  logic         push_s;
  fetch_entry_t push_entry_s;
  logic         pop_s;
  logic         issue_s;
  logic [CW:0]  occ_s;
  logic [CW-1:0] count_s;
  logic         head_valid_s;
  fetch_entry_t head_s;

`ifdef FETCH_ALIGN_CHK_EN
  assign tgt_s = redirect_pc;
  assign mis_s = (redirect_pc[1:0] != 2'b00);
`else
  assign tgt_s = redirect_pc & 32'hFFFF_FFFC;
  assign mis_s = 1'b0;
`endif

  assign push_s = inflight_r || fault_pend_r;

  // Buffer write data: a pending fault entry or the ROM word with its PC.
  always_comb begin
    if (fault_pend_r) begin
      push_entry_s = '{pc: pc_r, inst: 32'h0000_0000, misalign: 1'b1};
    end else begin
      push_entry_s = '{pc: inflight_pc_r, inst: ibus.data, misalign: 1'b0};
    end
  end

  // Issue when the buffer can still absorb everything already requested.
  always_comb begin
    pop_s = head_valid_s && out_ready;
    occ_s = {1'b0, count_s} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
    if (rst || redirect_valid || halt_r || fault_pend_r) begin
      issue_s = 1'b0;
    end else begin
      issue_s = (occ_s < (CW+1)'(DEPTH));
    end
  end

  // PC sequencing; a redirect drops the response arriving this cycle via flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      inflight_pc_r <= RESET_PC;
      inflight_r    <= 1'b0;
      halt_r        <= 1'b0;
      fault_pend_r  <= 1'b0;
    end else if (redirect_valid) begin
      pc_r         <= tgt_s;
      inflight_r   <= 1'b0;
      halt_r       <= mis_s;
      fault_pend_r <= mis_s;
    end else begin
      inflight_r    <= issue_s;
      inflight_pc_r <= pc_r;
      fault_pend_r  <= 1'b0;
      if (issue_s) begin
        pc_r <= pc_r + INST_STEP;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head_valid (head_valid_s),
    .head       (head_s),
    .count      (count_s)
  );

  assign ibus.en      = issue_s;
  assign ibus.addr    = pc_r;
  assign out_valid    = head_valid_s;
  assign out_pc       = head_s.pc;
  assign out_inst     = head_s.inst;
  assign out_misalign = head_s.misalign;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the fetch-buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  the single clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ibus  i_instbus.master  en/addr out, data in  the instruction ROM port.
REQ-006 SHALL have port redirect_valid  input  1  a branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  inst_addr_t  the redirect target.
REQ-008 SHALL have port out_valid  output  1  the head entry is valid toward decode.
REQ-009 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-010 SHALL have port out_pc  output  inst_addr_t  the head entry PC.
REQ-011 SHALL have port out_inst  output  inst_data_t  the head entry instruction word.
REQ-012 SHALL have port out_misalign  output  1  the head entry is a misaligned-fetch fault.

Function
REQ-013 SHALL treat ibus as synchronous: data is valid exactly one cycle after a cycle with en=1.
REQ-014 SHALL issue a fetch (en=1, addr=pc) only when occupancy + inflight - pop_this_cycle < DEPTH, and then advance pc by 4.
REQ-015 SHALL wrap pc modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-016 SHALL push each returned word, with its issuing PC, into the buffer in the response cycle.
REQ-017 SHALL complete a transfer on out_valid && out_ready and then pop the head entry.
REQ-018 SHALL allow a push and a pop in the same cycle at any occupancy, including full.
REQ-019 SHALL hold out_pc, out_inst and out_misalign stable while out_valid && !out_ready.
REQ-020 SHALL, on redirect_valid, complete any handshake of that cycle normally.
REQ-021 SHALL, on redirect_valid, flush all other buffered entries.
REQ-022 SHALL, on redirect_valid, discard the in-flight response due next cycle.
REQ-023 SHALL, on redirect_valid, drive en=0 in that cycle and set pc <= redirect_pc.
REQ-024 SHALL give redirect priority over issue; its first fetch is issued the next cycle and its out_valid rises two cycles after the redirect.
REQ-025 SHALL give back-to-back redirects last-wins behaviour, with no stale entries surfacing.
REQ-026 SHALL, with out_ready held 1 and no redirects, sustain one instruction per cycle after a 2-cycle startup.

Reset
REQ-027 SHALL, while rst=1, hold pc=RESET_PC, buffer empty, inflight=0, en=0, addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0, out_misalign=0.
REQ-028 SHALL abort any in-flight fetch on reset mid-operation, with no entry surviving.
REQ-029 SHALL issue the first fetch (addr=RESET_PC) in the first clock edge's cycle after rst falls.

Configuration
REQ-030 SHALL, with FETCH_ALIGN_CHK_EN defined, not access the bus for a redirect_pc with bits [1:0] != 0.
REQ-031 SHALL, with FETCH_ALIGN_CHK_EN defined and such a redirect, enqueue one entry (pc=redirect_pc, inst=0, misalign=1) and stop fetching until the next redirect.
REQ-032 SHALL, without FETCH_ALIGN_CHK_EN, force redirect_pc[1:0] to 0 and tie out_misalign to 0.

Structure
REQ-033 SHALL place fetch_entry_t (pc, inst, misalign) and the INST_STEP=4 constant in project_types, next to inst_addr_t and inst_data_t.
REQ-034 SHALL implement the buffer as sub-module fetch_fifo (DEPTH-entry, fall-through head, flush input, count output).

Verification
REQ-035 SHALL verify reset and stream: release rst with out_ready=1 -> addr 0,4,8... from cycle 0; out_valid from cycle 1; one inst per cycle; out_pc matches addr one cycle later.
REQ-036 SHALL verify backpressure: out_ready=0 for 5 cycles -> en drops after DEPTH outstanding; out_* stable; on release, no instruction lost or duplicated.
REQ-037 SHALL verify redirect: redirect_pc=32'h0000_0100 while 2 entries are buffered -> en=0 that cycle; addr=32'h100 next cycle; out_pc 32'h100 next valid; no old PCs after.
REQ-038 SHALL verify a redirect coinciding with a handshake: the current head is consumed once; same-cycle and next-cycle redirects -> only the second target is fetched.
REQ-039 SHALL verify wrap: redirect to 32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 SHALL verify the alignment check (macro on): redirect_pc=32'h0000_0102 -> one entry with misalign=1, inst=0 and no en; (macro off): addr=32'h0000_0100 and misalign=0.
